// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: access sizes, FSM states
// and the alignment predicate.
package dmem_lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        DONE = 2'b11
    } lsu_state_t;

    // Encoding 2'b11 behaves as a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] low);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = low[0];
            default: mis = (low != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_lsu_lane_align.sv
// Combinational lane steering: extracts/extends a loaded sub-word and merges store
// data into a read word for read-modify-write.
module lsu_lane_align
    import dmem_lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] ext_data,
    output logic [31:0] merge_data
);

    logic [4:0]  bsh_s;
    logic [4:0]  hsh_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Half accesses take their lane from addr[1] only, so bit 0 never shifts them.
    assign bsh_s  = {offset, 3'b000};
    assign hsh_s  = {offset[1], 4'b0000};
    assign byte_s = word[bsh_s +: 8];
    assign half_s = word[hsh_s +: 16];

    // Load path: select lane and extend.
    always_comb begin
        ext_data = word;
        case (size)
            SZ_BYTE: ext_data = {{24{sign_ext & byte_s[7]}}, byte_s};
            SZ_HALF: ext_data = {{16{sign_ext & half_s[15]}}, half_s};
            default: ext_data = word;
        endcase
    end

    // Store path: replace the target lane of the read word.
    always_comb begin
        merge_data = wdata;
        case (size)
            SZ_BYTE: merge_data = (word & ~(32'h0000_00FF << bsh_s)) | ({24'h00_0000, wdata[7:0]} << bsh_s);
            SZ_HALF: merge_data = (word & ~(32'h0000_FFFF << hsh_s)) | ({16'h0000, wdata[15:0]} << hsh_s);
            default: merge_data = wdata;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit driving a word-wide data memory; sub-word stores use read-modify-write.
// Optional macro ALIGN_CHECK_EN: reject misaligned half/word requests with an err pulse.
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          we,
    input  logic [1:0]    size,
    input  logic          sign_ext,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic          busy,
    output logic          done,
    output logic [31:0]   rdata,
    output logic          err,
    output logic          DM_CS,
    output logic          DM_R,
    output logic          DM_W,
    output logic [AW-1:0] dm_addr,
    output logic [31:0]   dm_wdata,
    input  logic [31:0]   dm_rdata
);

    lsu_state_t    state_r;
    lsu_state_t    state_nxt_s;
    logic          we_r;
    logic          sign_ext_r;
    logic [1:0]    size_r;
    logic [AW-1:0] addr_r;
    logic [31:0]   wbuf_r;
    logic [31:0]   rdata_r;
    logic [31:0]   ext_s;
    logic [31:0]   merge_s;
    logic          accept_s;
    logic          misaligned_s;

    assign accept_s = (state_r == IDLE) && req;

`ifdef ALIGN_CHECK_EN
    logic err_flag_r;

    assign misaligned_s = is_misaligned(size, addr[1:0]);

    // Remember whether the accepted request was rejected for alignment.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_flag_r <= 1'b0;
        end else if (accept_s) begin
            err_flag_r <= misaligned_s;
        end
    end

    assign err = (state_r == DONE) && err_flag_r;
`else
    assign misaligned_s = 1'b0;
    assign err          = 1'b0;
`endif

    lsu_lane_align u_lane_align (
        .word       (dm_rdata),
        .wdata      (wbuf_r),
        .offset     (addr_r[1:0]),
        .size       (size_r),
        .sign_ext   (sign_ext_r),
        .ext_data   (ext_s),
        .merge_data (merge_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; word stores skip the read phase.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (!req) begin
                    state_nxt_s = IDLE;
                end else if (misaligned_s) begin
                    state_nxt_s = DONE;
                end else if (we && size[1]) begin
                    state_nxt_s = WR;
                end else begin
                    state_nxt_s = RD;
                end
            end
            RD:      state_nxt_s = we_r ? WR : DONE;
            WR:      state_nxt_s = DONE;
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Request latch, merge/write buffer and load result.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_r       <= 1'b0;
            sign_ext_r <= 1'b0;
            size_r     <= SZ_BYTE;
            addr_r     <= {AW{1'b0}};
            wbuf_r     <= 32'h0000_0000;
            rdata_r    <= 32'h0000_0000;
        end else begin
            if (accept_s) begin
                we_r       <= we;
                sign_ext_r <= sign_ext;
                size_r     <= size;
                addr_r     <= addr;
                wbuf_r     <= wdata;
            end
            if (state_r == RD) begin
                if (we_r) begin
                    wbuf_r <= merge_s;
                end else begin
                    rdata_r <= ext_s;
                end
            end
        end
    end

    // Strobes come only from the state register, gated so reset kills an in-flight write.
    assign DM_CS    = ((state_r == RD) || (state_r == WR)) && !rst;
    assign DM_R     = (state_r == RD) && !rst;
    assign DM_W     = (state_r == WR) && !rst;
    assign dm_addr  = {addr_r[AW-1:2], 2'b00};
    assign dm_wdata = wbuf_r;
    assign busy     = (state_r != IDLE);
    assign done     = (state_r == DONE);
    assign rdata    = rdata_r;

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: directed requests push expected completions and writes;
// a negedge monitor pops and compares them against the DUT.
module tb_dmem_lsu;
    import dmem_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic        sign_ext = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        busy, done, err, DM_CS, DM_R, DM_W;
    logic [31:0] rdata, dm_addr, dm_wdata, dm_rdata;
    logic [31:0] mem [0:63];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          issue;
    } exp_t;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    exp_t        exp_q[$];
    wr_t         wr_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          cs_cycles = 0;
    logic [31:0] last_rdata = 32'h0;

    dmem_lsu #(.AW(32)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata), .err(err),
        .DM_CS(DM_CS), .DM_R(DM_R), .DM_W(DM_W), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign dm_rdata = mem[dm_addr[7:2]];

    always @(posedge clk) begin
        if (DM_CS && DM_W) mem[dm_addr[7:2]] <= dm_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Monitor: every write strobe and every done pulse must match a queued expectation.
    always @(negedge clk) begin
        if (DM_CS) cs_cycles++;
        if (DM_W) begin
            if (wr_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: addr %h data %h with none expected", dm_addr, dm_wdata);
            end else begin
                wr_t w;
                w = wr_q.pop_front();
                check("wr_addr", dm_addr, w.addr);
                check("wr_data", dm_wdata, w.data);
            end
        end
        if (done) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: rdata %h err %0b with none expected", rdata, err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rdata", rdata, e.rdata);
                check("err", {31'h0, err}, {31'h0, e.err});
                check("latency", 32'(cyc - e.issue), 32'(e.lat));
            end
        end
    end

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_timeout: busy still %0b after 50 cycles", busy);
        end
    endtask

    task automatic issue(input logic w, input logic [1:0] sz, input logic sx, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err,
                         input int lat, input logic has_wr, input logic [31:0] exp_wd);
        exp_t e;
        wr_t  wr;
        wait_idle();
        we = w; size = sz; sign_ext = sx; addr = a; wdata = d; req = 1'b1;
        e.rdata = exp_rd; e.err = exp_err; e.lat = lat; e.issue = cyc;
        exp_q.push_back(e);
        if (has_wr) begin
            wr.addr = {a[31:2], 2'b00};
            wr.data = exp_wd;
            wr_q.push_back(wr);
        end
        last_rdata = exp_rd;
        @(negedge clk);
        req = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        int   c0;
        int   cs0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done_err", {30'h0, done, err}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_strobes", {29'h0, DM_CS, DM_R, DM_W}, 32'h0);
        check("rst_dm_addr", dm_addr, 32'h0);
        check("rst_dm_wdata", dm_wdata, 32'h0);

        // Word store/load and byte/half read-modify-write.
        issue(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEAD_BEEF, last_rdata, 1'b0, 2, 1'b1, 32'hDEAD_BEEF);
        issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 1'b0, 32'h0);
        issue(1'b1, SZ_WORD, 1'b0, 32'h10, 32'h1122_3344, last_rdata, 1'b0, 2, 1'b1, 32'h1122_3344);
        issue(1'b1, SZ_BYTE, 1'b0, 32'h12, 32'h0000_00AB, last_rdata, 1'b0, 3, 1'b1, 32'h11AB_3344);
        issue(1'b1, SZ_WORD, 1'b0, 32'h20, 32'h80FF_7F01, last_rdata, 1'b0, 2, 1'b1, 32'h80FF_7F01);
        issue(1'b0, SZ_BYTE, 1'b1, 32'h21, 32'h0, 32'h0000_007F, 1'b0, 2, 1'b0, 32'h0);
        issue(1'b0, SZ_BYTE, 1'b1, 32'h22, 32'h0, 32'hFFFF_FFFF, 1'b0, 2, 1'b0, 32'h0);
        issue(1'b0, SZ_HALF, 1'b0, 32'h22, 32'h0, 32'h0000_80FF, 1'b0, 2, 1'b0, 32'h0);
        issue(1'b0, SZ_HALF, 1'b1, 32'h22, 32'h0, 32'hFFFF_80FF, 1'b0, 2, 1'b0, 32'h0);
        issue(1'b1, SZ_HALF, 1'b0, 32'h22, 32'h1234_5566, last_rdata, 1'b0, 3, 1'b1, 32'h5566_7F01);
        issue(1'b0, SZ_BYTE, 1'b0, 32'h23, 32'h0, 32'h0000_0055, 1'b0, 2, 1'b0, 32'h0);

        // Reset during the WR cycle of a byte store: no write, no done.
        wait_idle();
        we = 1'b1; size = SZ_BYTE; sign_ext = 1'b0; addr = 32'h12; wdata = 32'h0000_00CD; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        #1;
        check("rstwr_dm_w", {31'h0, DM_W}, 32'h0);
        check("rstwr_dm_cs", {31'h0, DM_CS}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstwr_busy", {31'h0, busy}, 32'h0);
        check("rstwr_done", {31'h0, done}, 32'h0);
        check("rstwr_rdata", rdata, 32'h0);
        last_rdata = 32'h0;
        issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h11AB_3344, 1'b0, 2, 1'b0, 32'h0);

        // req held high across two loads: second accepted the cycle after done.
        wait_idle();
        we = 1'b0; size = SZ_WORD; sign_ext = 1'b0; addr = 32'h20; req = 1'b1;
        c0 = cyc;
        e.rdata = 32'h5566_7F01; e.err = 1'b0; e.lat = 2; e.issue = c0;
        exp_q.push_back(e);
        e.issue = c0 + 3;
        exp_q.push_back(e);
        repeat (4) @(negedge clk);
        req = 1'b0;
        last_rdata = 32'h5566_7F01;

        // A store request raised only while busy (RD and DONE) must be ignored.
        wait_idle();
        we = 1'b0; size = SZ_HALF; sign_ext = 1'b0; addr = 32'h10; req = 1'b1;
        e.rdata = 32'h0000_3344; e.err = 1'b0; e.lat = 2; e.issue = cyc;
        exp_q.push_back(e);
        last_rdata = 32'h0000_3344;
        @(negedge clk);
        we = 1'b1; size = SZ_WORD; addr = 32'h20; wdata = 32'hBAD0_BAD0;
        @(negedge clk);
        @(posedge clk);
        #1 req = 1'b0;
        issue(1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 32'h5566_7F01, 1'b0, 2, 1'b0, 32'h0);

        // Misaligned word load.
        wait_idle();
        cs0 = cs_cycles;
`ifdef ALIGN_CHECK_EN
        issue(1'b0, SZ_WORD, 1'b0, 32'h13, 32'h0, last_rdata, 1'b1, 1, 1'b0, 32'h0);
        wait_idle();
        check("misalign_no_cs", 32'(cs_cycles - cs0), 32'h0);
`else
        issue(1'b0, SZ_WORD, 1'b0, 32'h13, 32'h0, 32'h11AB_3344, 1'b0, 2, 1'b0, 32'h0);
        wait_idle();
        check("misalign_one_cs", 32'(cs_cycles - cs0), 32'h1);
`endif

        repeat (3) @(negedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'h0);
        check("wr_q_drained", 32'(wr_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
